vga_sync_gen: RTL and testbench

//  Raster timing generator that sits directly upstream of the tangram pixel/colour stage.

---
 rtl/vga_sync_gen.sv | 95 +++++++++
 tb/tb_vga_sync_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// Raster timing generator: divides clk_i to a pixel enable, runs hc/vc, and decodes
// sync, visible-area and line/frame tick outputs straight from the registered counters.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        pix_en_o,
    output logic [10:0] hc_o,
    output logic [10:0] vc_o,
    output logic        vidon_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        line_tick_o,
    output logic        frame_tick_o
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [10:0]      hc_q, hc_d;
    logic [10:0]      vc_q, vc_d;
    logic             pix_tick;
    logic             h_wrap;
    logic             v_wrap;
    logic             hs_act;
    logic             vs_act;

    always_comb begin
        pix_tick = (div_q == DIV_LAST);
        h_wrap   = (hc_q == H_LAST);
        v_wrap   = (vc_q == V_LAST);
        div_d    = pix_tick ? '0 : div_q + DIV_W'(1);
        hc_d     = hc_q;
        vc_d     = vc_q;
        if (pix_tick) begin
            if (h_wrap) begin
                hc_d = '0;
                vc_d = v_wrap ? '0 : vc_q + 11'd1;
            end else begin
                hc_d = hc_q + 11'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= '0;
            hc_q  <= '0;
            vc_q  <= '0;
        end else begin
            div_q <= div_d;
            hc_q  <= hc_d;
            vc_q  <= vc_d;
        end
    end

    // Decodes are forced inactive while rst_i is high so a reset landing mid-sync
    // or on a wrap cycle never leaks a sync level or a tick.
    always_comb begin
        hs_act = ~rst_i & (hc_q >= HS_START) & (hc_q < HS_END);
        vs_act = ~rst_i & (vc_q >= VS_START) & (vc_q < VS_END);
    end

    assign pix_en_o     = ~rst_i & pix_tick;
    assign hc_o         = hc_q;
    assign vc_o         = vc_q;
    assign vidon_o      = ~rst_i & (hc_q < H_VIS) & (vc_q < V_VIS);
    assign hsync_o      = hs_act ? SYNC_POL : ~SYNC_POL;
    assign vsync_o      = vs_act ? SYNC_POL : ~SYNC_POL;
    assign line_tick_o  = pix_en_o & h_wrap;
    assign frame_tick_o = line_tick_o & v_wrap;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: fixed vectors on the default 640x480 timing, plus random
// resets on two reduced-size rasters checked against an arithmetic reference model.
module tb_vga_sync_gen;

    typedef struct {
        bit rst;
        int n;
        int hc;
        int vc;
        bit pe;
        bit vid;
        bit hs;
        bit vs;
        bit lt;
        bit ft;
    } vec_t;

    typedef struct {
        bit pe;
        int hc;
        int vc;
        bit vid;
        bit hs;
        bit vs;
        bit lt;
        bit ft;
    } exp_t;

    int n_cmp  = 0;
    int n_fail = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_r = 1'b1;

    logic pe_a, vid_a, hs_a, vs_a, lt_a, ft_a;
    logic [10:0] hc_a, vc_a;
    logic pe_b, vid_b, hs_b, vs_b, lt_b, ft_b;
    logic [10:0] hc_b, vc_b;
    logic pe_c, vid_c, hs_c, vs_c, lt_c, ft_c;
    logic [10:0] hc_c, vc_c;

    vga_sync_gen u_dut_a (
        .clk_i(clk), .rst_i(rst_a), .pix_en_o(pe_a), .hc_o(hc_a), .vc_o(vc_a),
        .vidon_o(vid_a), .hsync_o(hs_a), .vsync_o(vs_a),
        .line_tick_o(lt_a), .frame_tick_o(ft_a)
    );

    // Reduced raster: 15 px x 8 lines, active-high sync, 3 clks per pixel.
    vga_sync_gen #(
        .CLK_DIV(3), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst_r), .pix_en_o(pe_b), .hc_o(hc_b), .vc_o(vc_b),
        .vidon_o(vid_b), .hsync_o(hs_b), .vsync_o(vs_b),
        .line_tick_o(lt_b), .frame_tick_o(ft_b)
    );

    // Same raster, undivided clock, active-low sync.
    vga_sync_gen #(
        .CLK_DIV(1), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
    ) u_dut_c (
        .clk_i(clk), .rst_i(rst_r), .pix_en_o(pe_c), .hc_o(hc_c), .vc_o(vc_c),
        .vidon_o(vid_c), .hsync_o(hs_c), .vsync_o(vs_c),
        .line_tick_o(lt_c), .frame_tick_o(ft_c)
    );

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // t = clk edges since the last edge that sampled reset high.
    function automatic exp_t ref_model(input int t, input bit rst, input int div,
                                       input int hv, input int hf, input int hs, input int hb,
                                       input int vv, input int vf, input int vs, input int vb,
                                       input bit pol);
        exp_t e;
        int htot = hv + hf + hs + hb;
        int vtot = vv + vf + vs + vb;
        int p    = t / div;
        e.hc  = p % htot;
        e.vc  = (p / htot) % vtot;
        e.pe  = !rst && (t % div == div - 1);
        e.vid = !rst && e.hc < hv && e.vc < vv;
        e.hs  = (!rst && e.hc >= hv + hf && e.hc < hv + hf + hs) ? pol : !pol;
        e.vs  = (!rst && e.vc >= vv + vf && e.vc < vv + vf + vs) ? pol : !pol;
        e.lt  = e.pe && (e.hc == htot - 1);
        e.ft  = e.lt && (e.vc == vtot - 1);
        return e;
    endfunction

    task automatic chk_all(input string tag, input exp_t e, input logic pe,
                           input logic [10:0] hc, input logic [10:0] vc, input logic vid,
                           input logic hs, input logic vs, input logic lt, input logic ft);
        chk({tag, ".pix_en"},     int'(pe),  int'(e.pe));
        chk({tag, ".hc"},         int'(hc),  e.hc);
        chk({tag, ".vc"},         int'(vc),  e.vc);
        chk({tag, ".vidon"},      int'(vid), int'(e.vid));
        chk({tag, ".hsync"},      int'(hs),  int'(e.hs));
        chk({tag, ".vsync"},      int'(vs),  int'(e.vs));
        chk({tag, ".line_tick"},  int'(lt),  int'(e.lt));
        chk({tag, ".frame_tick"}, int'(ft),  int'(e.ft));
    endtask

    vec_t vecs[16];
    int   t_b, t_c, hold;
    int   ft_cnt_b, ft_cnt_c, lt_cnt_b, vs_cnt_b, vs_cnt_c, pe_cnt_c;
    exp_t eb, ec;

    initial begin
        //            rst  n     hc   vc  pe vid hs vs lt ft
        vecs[0]  = '{1'b1, 3,    0,   0,  0, 0,  1, 1, 0, 0};
        vecs[1]  = '{1'b0, 0,    0,   0,  0, 1,  1, 1, 0, 0};
        vecs[2]  = '{1'b0, 3,    0,   0,  1, 1,  1, 1, 0, 0};
        vecs[3]  = '{1'b0, 1,    1,   0,  0, 1,  1, 1, 0, 0};
        vecs[4]  = '{1'b0, 2619, 655, 0,  1, 0,  1, 1, 0, 0};
        vecs[5]  = '{1'b0, 1,    656, 0,  0, 0,  0, 1, 0, 0};
        vecs[6]  = '{1'b0, 383,  751, 0,  1, 0,  0, 1, 0, 0};
        vecs[7]  = '{1'b0, 1,    752, 0,  0, 0,  1, 1, 0, 0};
        vecs[8]  = '{1'b0, 191,  799, 0,  1, 0,  1, 1, 1, 0};
        vecs[9]  = '{1'b0, 1,    0,   1,  0, 1,  1, 1, 0, 0};
        vecs[10] = '{1'b0, 2556, 639, 1,  0, 1,  1, 1, 0, 0};
        vecs[11] = '{1'b0, 4,    640, 1,  0, 0,  1, 1, 0, 0};
        vecs[12] = '{1'b0, 240,  700, 1,  0, 0,  0, 1, 0, 0};
        vecs[13] = '{1'b1, 0,    700, 1,  0, 0,  1, 1, 0, 0};
        vecs[14] = '{1'b1, 1,    0,   0,  0, 0,  1, 1, 0, 0};
        vecs[15] = '{1'b0, 4,    1,   0,  0, 1,  1, 1, 0, 0};

        for (int i = 0; i < 16; i++) begin
            exp_t e;
            rst_a = vecs[i].rst;
            if (vecs[i].n == 0) #1;
            else begin
                repeat (vecs[i].n) @(posedge clk);
                #1;
            end
            e = '{vecs[i].pe, vecs[i].hc, vecs[i].vc, vecs[i].vid,
                  vecs[i].hs, vecs[i].vs, vecs[i].lt, vecs[i].ft};
            chk_all($sformatf("vec%0d", i), e, pe_a, hc_a, vc_a, vid_a, hs_a, vs_a, lt_a, ft_a);
        end

        // Random reset pulses on the reduced rasters, checked every clk.
        t_b  = 0;
        t_c  = 0;
        hold = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            if (rst_r) begin
                t_b = 0;
                t_c = 0;
            end else begin
                t_b++;
                t_c++;
            end
            #1;
            if (hold > 0) begin
                hold--;
                rst_r = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                hold  = $urandom_range(0, 2);
                rst_r = 1'b1;
            end else begin
                rst_r = 1'b0;
            end
            #1;
            eb = ref_model(t_b, rst_r, 3, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1);
            ec = ref_model(t_c, rst_r, 1, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0);
            chk_all("rnd_b", eb, pe_b, hc_b, vc_b, vid_b, hs_b, vs_b, lt_b, ft_b);
            chk_all("rnd_c", ec, pe_c, hc_c, vc_c, vid_c, hs_c, vs_c, lt_c, ft_c);
        end

        // Two clean frames of B (720 clks) are six frames of C.
        rst_r = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_r = 1'b0;
        ft_cnt_b = 0; ft_cnt_c = 0; lt_cnt_b = 0;
        vs_cnt_b = 0; vs_cnt_c = 0; pe_cnt_c = 0;
        for (int cyc = 0; cyc < 720; cyc++) begin
            #1;
            ft_cnt_b += int'(ft_b);
            ft_cnt_c += int'(ft_c);
            lt_cnt_b += int'(lt_b);
            vs_cnt_b += int'(vs_b);
            vs_cnt_c += int'(!vs_c);
            pe_cnt_c += int'(pe_c);
            @(posedge clk);
        end
        chk("frame_b.frame_ticks", ft_cnt_b, 2);
        chk("frame_c.frame_ticks", ft_cnt_c, 6);
        chk("frame_b.line_ticks",  lt_cnt_b, 16);
        chk("frame_b.vsync_clks",  vs_cnt_b, 180);
        chk("frame_c.vsync_clks",  vs_cnt_c, 180);
        chk("frame_c.pix_en_clks", pe_cnt_c, 720);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
